// File: rtl/t03_sprite_fetch_ctrl.sv
// Sprite fetch controller: at each vblank start, reloads changed player sprite
// bitmaps over a byte-wide req/ack port and commits them only while in vblank.
module t03_sprite_fetch_ctrl #(
  parameter int SPRITE_BYTES = 300,
  parameter int IDX_W        = 4,
  parameter int ADDR_W       = 13,
  parameter int V_ACTIVE     = 600,
  parameter int V_TOTAL      = 628
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               Vcnt,
  input  logic [10:0]               Hcnt,
  input  logic [IDX_W-1:0]          p1_idx,
  input  logic [IDX_W-1:0]          p2_idx,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_rdata,
  output logic [SPRITE_BYTES*8-1:0] player1,
  output logic [SPRITE_BYTES*8-1:0] player2,
  output logic                      p1_valid,
  output logic                      p2_valid,
  output logic                      busy,
  output logic                      load_done
);

  localparam int BM_W = SPRITE_BYTES * 8;
  localparam int K_W  = $clog2(SPRITE_BYTES);
  localparam logic [K_W-1:0] LAST_K = K_W'(SPRITE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEL,
    FETCH,
    COMMIT
  } state_t;

  state_t state, state_d;

  logic [K_W-1:0]   k;
  logic             cur_p2;
  logic [IDX_W-1:0] req_idx1, req_idx2;
  logic [IDX_W-1:0] loaded_idx1, loaded_idx2;
  logic             dirty1, dirty2;
  logic             pass_commit;
  logic [BM_W-1:0]  staging;

  // Control strobes decoded from the current state
  logic do_latch;
  logic do_start;
  logic start_p2;
  logic do_byte;
  logic do_last;
  logic do_commit;
  logic do_abort;
  logic do_done;

  logic vblank_start;
  logic in_vblank;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] start_idx;

  // Counts at or past V_TOTAL never occur; they are treated as active video.
  assign in_vblank    = (Vcnt >= 11'(V_ACTIVE)) && (Vcnt < 11'(V_TOTAL));
  assign vblank_start = (Vcnt == 11'(V_ACTIVE)) && (Hcnt == '0);
  assign busy         = (state != IDLE);
  assign cur_idx      = cur_p2 ? req_idx2 : req_idx1;
  assign start_idx    = start_p2 ? req_idx2 : req_idx1;

  // Byte address idx*SPRITE_BYTES + k, kept modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] sprite_addr(input logic [IDX_W-1:0] idx,
                                                    input logic [K_W-1:0]   kk);
    return ADDR_W'(idx) * ADDR_W'(SPRITE_BYTES) + ADDR_W'(kk);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d   = state;
    do_latch  = 1'b0;
    do_start  = 1'b0;
    start_p2  = 1'b0;
    do_byte   = 1'b0;
    do_last   = 1'b0;
    do_commit = 1'b0;
    do_abort  = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE: begin
        if (vblank_start) state_d = LATCH;
      end
      LATCH: begin
        do_latch = 1'b1;
        state_d  = SEL;
      end
      SEL: begin
        if (dirty1) begin
          do_start = 1'b1;
          state_d  = FETCH;
        end else if (dirty2) begin
          do_start = 1'b1;
          start_p2 = 1'b1;
          state_d  = FETCH;
        end else begin
          do_done = pass_commit;
          state_d = IDLE;
        end
      end
      FETCH: begin
        // Leaving vblank wins over an ack in the same cycle: that byte is dropped.
        if (!in_vblank) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else if (mem_req && mem_ack) begin
          do_byte = 1'b1;
          if (k == LAST_K) begin
            do_last = 1'b1;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (!in_vblank) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else begin
          do_commit = 1'b1;
          state_d   = SEL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      cur_p2      <= 1'b0;
      req_idx1    <= '0;
      req_idx2    <= '0;
      loaded_idx1 <= '0;
      loaded_idx2 <= '0;
      dirty1      <= 1'b1;
      dirty2      <= 1'b1;
      pass_commit <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      player1     <= '0;
      player2     <= '0;
      p1_valid    <= 1'b0;
      p2_valid    <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= do_done;

      if (do_latch) begin
        req_idx1    <= p1_idx;
        req_idx2    <= p2_idx;
        dirty1      <= dirty1 | (p1_idx != loaded_idx1);
        dirty2      <= dirty2 | (p2_idx != loaded_idx2);
        pass_commit <= 1'b0;
      end

      if (do_start) begin
        cur_p2   <= start_p2;
        k        <= '0;
        mem_req  <= 1'b1;
        mem_addr <= sprite_addr(start_idx, '0);
      end

      if (do_byte) begin
        if (do_last) begin
          mem_req <= 1'b0;
        end else begin
          k        <= k + K_W'(1);
          mem_addr <= sprite_addr(cur_idx, k + K_W'(1));
        end
      end

      if (do_abort) mem_req <= 1'b0;

      if (do_commit) begin
        pass_commit <= 1'b1;
        if (cur_p2) begin
          player2     <= staging;
          loaded_idx2 <= req_idx2;
          dirty2      <= 1'b0;
          p2_valid    <= 1'b1;
        end else begin
          player1     <= staging;
          loaded_idx1 <= req_idx1;
          dirty1      <= 1'b0;
          p1_valid    <= 1'b1;
        end
      end
    end
  end

  // NOTE: the staging buffer is left out of reset; every commit is preceded by
  // a full SPRITE_BYTES refill, so its power-up contents are never visible.
  // Shifting in at the LSB end leaves byte 0 in the MSB byte after the last byte.
  always_ff @(posedge clk) begin
    if (do_byte) staging <= {staging[BM_W-9:0], mem_rdata};
  end

endmodule

// File: tb/tb_t03_sprite_fetch_ctrl.sv
// Directed bench for t03_sprite_fetch_ctrl: drives vblank passes against a
// behavioural byte memory and compares addresses, bitmaps and status outputs.
module tb_t03_sprite_fetch_ctrl;

  localparam int SPRITE_BYTES = 300;
  localparam int V_ACTIVE     = 600;
  localparam int BM_W         = SPRITE_BYTES * 8;
  localparam int CYCLE_BUDGET = 4000;

  logic            clk = 1'b0;
  logic            rst;
  logic [10:0]     Vcnt, Hcnt;
  logic [3:0]      p1_idx, p2_idx;
  logic            mem_req;
  logic [12:0]     mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [BM_W-1:0] player1, player2;
  logic            p1_valid, p2_valid, busy, load_done;

  int checks = 0;
  int errors = 0;

  int          exp_addr_q[$];
  int          n_xfer, n_addr_err, n_stable_err, n_done;
  bit          stall_pending = 1'b0;
  logic [12:0] stall_addr;
  bit          timed_out;

  t03_sprite_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Vcnt      (Vcnt),
    .Hcnt      (Hcnt),
    .p1_idx    (p1_idx),
    .p2_idx    (p2_idx),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .player1   (player1),
    .player2   (player2),
    .p1_valid  (p1_valid),
    .p2_valid  (p2_valid),
    .busy      (busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  // Memory image: a byte that depends on the whole address.
  function automatic logic [7:0] mem_byte(input int addr);
    logic [31:0] v;
    v = addr * 37 + (addr >> 4) + 32'h5A;
    return v[7:0];
  endfunction

  function automatic logic [BM_W-1:0] exp_bitmap(input int idx);
    logic [BM_W-1:0] bm;
    for (int b = 0; b < SPRITE_BYTES; b++)
      bm[BM_W-1-8*b -: 8] = mem_byte(idx * SPRITE_BYTES + b);
    return bm;
  endfunction

  // Index of the first differing byte (byte 0 = MSB byte), or -1 if equal.
  function automatic int first_diff(input logic [BM_W-1:0] a, input logic [BM_W-1:0] b);
    for (int i = 0; i < SPRITE_BYTES; i++)
      if (a[BM_W-1-8*i -: 8] !== b[BM_W-1-8*i -: 8]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_sprite(input int idx);
    for (int k = 0; k < SPRITE_BYTES; k++) exp_addr_q.push_back(idx * SPRITE_BYTES + k);
  endtask

  // Called at a negedge: present ack/data for the coming edge, log the cycle.
  task automatic drive_cycle(input logic ack);
    mem_ack   = ack;
    mem_rdata = mem_byte(int'(mem_addr));
    if (mem_req && ack) begin
      n_xfer++;
      if (exp_addr_q.size() == 0) n_addr_err++;
      else if (int'(mem_addr) != exp_addr_q.pop_front()) n_addr_err++;
    end
    if (load_done) n_done++;
    if (stall_pending && mem_req && (mem_addr !== stall_addr)) n_stable_err++;
    stall_pending = mem_req && !ack;
    stall_addr    = mem_addr;
    @(negedge clk);
  endtask

  // One vblank pass. stalls: random 0-3 cycle ack gaps. abort_after >= 0:
  // withhold ack after that many bytes, then leave vblank.
  task automatic run_pass(input bit stalls, input int abort_after, output bit tmo);
    int   stall_left;
    int   idle_cnt;
    int   cycles;
    logic a;
    n_xfer = 0; n_addr_err = 0; n_stable_err = 0; n_done = 0;
    stall_pending = 1'b0;
    stall_left = 0; idle_cnt = 0; cycles = 0; tmo = 1'b0;
    Vcnt = 11'(V_ACTIVE);
    Hcnt = 11'd0;
    drive_cycle(1'b1);
    Hcnt = 11'd1;
    while (busy && !tmo) begin
      a = 1'b1;
      if (abort_after >= 0 && n_xfer >= abort_after) begin
        a = 1'b0;
        idle_cnt++;
        if (idle_cnt == 5) Vcnt = 11'd0;
      end else if (stalls && mem_req) begin
        if (stall_left > 0) begin
          a = 1'b0;
          stall_left--;
        end else begin
          stall_left = $urandom_range(0, 3);
        end
      end
      drive_cycle(a);
      cycles++;
      if (cycles > CYCLE_BUDGET) tmo = 1'b1;
    end
    repeat (3) drive_cycle(1'b1);
  endtask

  initial begin
    rst = 1'b1; Vcnt = 11'd0; Hcnt = 11'd0;
    p1_idx = 4'd2; p2_idx = 4'd5; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ctrl", {mem_req, p1_valid, p2_valid, busy, load_done}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_players_nonzero", (player1 !== '0) || (player2 !== '0), 0);
    rst = 1'b0;
    @(negedge clk);

    // First vblank, zero-wait memory: P1 idx 2 then P2 idx 5
    expect_sprite(2); expect_sprite(5);
    run_pass(1'b0, -1, timed_out);
    check("p1_timeout", timed_out, 0);
    check("p1_xfers", n_xfer, 600);
    check("p1_addr_errs", n_addr_err, 0);
    check("p1_player1", first_diff(player1, exp_bitmap(2)), -1);
    check("p1_player2", first_diff(player2, exp_bitmap(5)), -1);
    check("p1_valids", {p1_valid, p2_valid}, 3);
    check("p1_load_done", n_done, 1);
    exp_addr_q.delete();

    // Same indices: nothing to fetch, no pulse, outputs hold
    run_pass(1'b0, -1, timed_out);
    check("p2_timeout", timed_out, 0);
    check("p2_xfers", n_xfer, 0);
    check("p2_load_done", n_done, 0);
    check("p2_player1", first_diff(player1, exp_bitmap(2)), -1);
    check("p2_player2", first_diff(player2, exp_bitmap(5)), -1);
    exp_addr_q.delete();

    // Only P2 changes 5 -> 7
    p2_idx = 4'd7;
    expect_sprite(7);
    run_pass(1'b0, -1, timed_out);
    check("p3_timeout", timed_out, 0);
    check("p3_xfers", n_xfer, 300);
    check("p3_addr_errs", n_addr_err, 0);
    check("p3_player1", first_diff(player1, exp_bitmap(2)), -1);
    check("p3_player2", first_diff(player2, exp_bitmap(7)), -1);
    check("p3_load_done", n_done, 1);
    exp_addr_q.delete();

    // Random ack stalls on P1 idx 9
    p1_idx = 4'd9;
    expect_sprite(9);
    run_pass(1'b1, -1, timed_out);
    check("p4_timeout", timed_out, 0);
    check("p4_xfers", n_xfer, 300);
    check("p4_addr_errs", n_addr_err, 0);
    check("p4_addr_stable_errs", n_stable_err, 0);
    check("p4_player1", first_diff(player1, exp_bitmap(9)), -1);
    check("p4_load_done", n_done, 1);
    exp_addr_q.delete();

    // Abort after 150 bytes of P1 idx 3: player1 keeps idx 9 image
    p1_idx = 4'd3;
    for (int k = 0; k < 150; k++) exp_addr_q.push_back(3 * SPRITE_BYTES + k);
    run_pass(1'b0, 150, timed_out);
    check("p5_timeout", timed_out, 0);
    check("p5_xfers", n_xfer, 150);
    check("p5_addr_errs", n_addr_err, 0);
    check("p5_mem_req", mem_req, 0);
    check("p5_player1", first_diff(player1, exp_bitmap(9)), -1);
    check("p5_load_done", n_done, 0);
    exp_addr_q.delete();

    // Next vblank refetches idx 3 from byte 0
    expect_sprite(3);
    run_pass(1'b0, -1, timed_out);
    check("p6_timeout", timed_out, 0);
    check("p6_xfers", n_xfer, 300);
    check("p6_addr_errs", n_addr_err, 0);
    check("p6_player1", first_diff(player1, exp_bitmap(3)), -1);
    check("p6_player2", first_diff(player2, exp_bitmap(7)), -1);
    check("p6_load_done", n_done, 1);
    exp_addr_q.delete();

    // Reset in the middle of a fetch
    p1_idx = 4'd4; p2_idx = 4'd6;
    n_xfer = 0;
    Vcnt = 11'(V_ACTIVE); Hcnt = 11'd0;
    drive_cycle(1'b1);
    Hcnt = 11'd1;
    for (int i = 0; i < 200 && n_xfer < 50; i++) drive_cycle(1'b1);
    check("p7_reached_fetch", n_xfer, 50);
    rst = 1'b1;
    drive_cycle(1'b1);
    check("p7_rst_ctrl", {mem_req, p1_valid, p2_valid, busy, load_done}, 0);
    check("p7_rst_addr", mem_addr, 0);
    check("p7_rst_players_nonzero", (player1 !== '0) || (player2 !== '0), 0);
    rst = 1'b0;
    @(negedge clk);
    exp_addr_q.delete();

    // Following vblank reloads both sprites
    expect_sprite(4); expect_sprite(6);
    run_pass(1'b0, -1, timed_out);
    check("p8_timeout", timed_out, 0);
    check("p8_xfers", n_xfer, 600);
    check("p8_addr_errs", n_addr_err, 0);
    check("p8_player1", first_diff(player1, exp_bitmap(4)), -1);
    check("p8_player2", first_diff(player2, exp_bitmap(6)), -1);
    check("p8_valids", {p1_valid, p2_valid}, 3);
    check("p8_load_done", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t03_sprite_fetch_ctrl.md
Name: t03_sprite_fetch_ctrl

Overview:
Sequences sprite bitmap loading for the two player display blocks. On each vertical-blanking start it checks whether either player's requested sprite index changed, then fetches the 300-byte (15x20, 8bpp) bitmap over a byte-wide req/ack memory port into a staging register. It commits each completed bitmap to that player's 2400-bit sprite bus, which feeds the player display blocks. Loads are serialized, P1 first then P2, and commits occur only during vblank so a frame never shows a half-loaded sprite.

Parameters:
SPRITE_BYTES, 300, bytes per sprite bitmap (x_length 15 * y_length 20)
IDX_W, 4, sprite index width
ADDR_W, 13, memory address width (must hold (2^IDX_W)*SPRITE_BYTES-1)
V_ACTIVE, 600, first Vcnt value of vertical blanking
V_TOTAL, 628, Vcnt wraps to 0 after V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
Vcnt  in  11  VGA vertical counter
Hcnt  in  11  VGA horizontal counter
p1_idx  in  IDX_W  sprite index requested for player 1
p2_idx  in  IDX_W  sprite index requested for player 2
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  byte address = idx*SPRITE_BYTES + k
mem_ack  in  1  transfer completes in any cycle with mem_req && mem_ack
mem_rdata  in  8  read data, valid when mem_ack=1
player1  out  2400  committed P1 bitmap
player2  out  2400  committed P2 bitmap
p1_valid  out  1  P1 bitmap committed at least once since reset
p2_valid  out  1  P2 bitmap committed at least once since reset
busy  out  1  high in any state other than IDLE
load_done  out  1  one-cycle pulse after the last commit of a vblank load pass

Behaviour:
- Reset (clk edge with rst=1) has priority over everything.
  - Reset values: player1=player2=0, p1_valid=p2_valid=0, mem_req=0, mem_addr=0, busy=0, load_done=0.
  - Reset also sets state=IDLE, k=0, loaded_idx1=loaded_idx2=0, dirty1=dirty2=1.
- vblank_start = (Vcnt==V_ACTIVE && Hcnt==0). in_vblank = (Vcnt>=V_ACTIVE).
- IDLE: on vblank_start go to LATCH.
- LATCH (1 cycle):
  - Capture p1_idx/p2_idx into req_idx1/req_idx2.
  - dirtyN |= (req_idxN != loaded_idxN). Go to SEL.
- SEL (1 cycle):
  - If dirty1: cur=P1, k=0, go to FETCH.
  - Else if dirty2: cur=P2, k=0, go to FETCH.
  - Else: pulse load_done if at least one commit happened in this pass, then go to IDLE.
- FETCH:
  - mem_req=1, mem_addr=req_idx_cur*SPRITE_BYTES+k, registered and stable while waiting.
  - On req&&ack: staging[2399-8k -: 8] <= mem_rdata, i.e. byte 0 lands in the MSB byte.
  - If k==SPRITE_BYTES-1, go to COMMIT; else k++ and mem_addr updates the next cycle. mem_req stays high, so back-to-back acks give 1 byte/cycle.
- COMMIT (1 cycle):
  - mem_req=0. playerN <= staging, loaded_idxN <= req_idxN, dirtyN <= 0, pN_valid <= 1. Go to SEL.
- Abort: if !in_vblank while in FETCH or COMMIT:
  - Go to IDLE, mem_req=0 the next cycle.
  - The byte acked in the abort cycle is discarded. No commit; playerN is unchanged; dirtyN stays set, so the load retries next vblank.
  - load_done is not pulsed.
- p1_idx/p2_idx changes mid-pass are ignored until the next LATCH.
- Throughput: LATCH+SEL+300 FETCH+COMMIT = 303 cycles min per sprite; both sprites fit in a 28-line vblank at 1056 clk/line.
- Address arithmetic is unsigned. The idx*300 product is computed at full width and truncated to ADDR_W; with defaults no overflow occurs (15*300+299 = 4799 < 8192).
- Zero-wait memory (ack tied high) and arbitrary ack stalls must both work.
- mem_req never drops while k<SPRITE_BYTES-1 in FETCH except on abort or reset.

Test Plan:
- Reset then first vblank, p1_idx=2, p2_idx=5, ack tied 1: addrs 600..899 then 1500..1799 back-to-back; player1/player2 equal the memory images with byte 0 at bits [2399:2392]; p1_valid=p2_valid=1; one load_done pulse.
- Second vblank with indices unchanged: LATCH, SEL, IDLE; mem_req stays 0; no load_done pulse; outputs hold.
- p2_idx 5->7 only: only addrs 2100..2399 fetched; player1 unchanged; player2 updated in COMMIT; load_done pulses once.
- Random 0-3 cycle ack stalls: mem_addr stays stable while mem_req=1 && !mem_ack; final bitmap is bit-exact.
- Drop ack after byte 150 of P1 until Vcnt wraps to 0: abort, mem_req=0, player1 keeps its old value; next vblank refetches from addr idx*300+0 and commits.
- Assert rst mid-FETCH: next cycle all outputs are 0, dirty1=dirty2=1, state=IDLE; the following vblank reloads both sprites.
